// File: rtl/prio_req_encoder.sv
// prio_req_encoder: registered priority encoder with sticky request capture.
// Request pulses are latched into a pending register. The highest-index
// pending request is offered on a valid/ready port, one index per handshake,
// and that pending bit is cleared when the offer is accepted.
//
// Optional feature macro: SEG_DISPLAY_EN (adds the seg0 7-segment output).
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   en         in   1      capture/offer enable
//   req        in   N_REQ  request pulses, each sets its pending bit
//   out_ready  in   1      consumer accepts the offered index
//   out_valid  out  1      offer present (registered)
//   out_idx    out  IDX_W  offered index (registered)
//   pending    out  N_REQ  pending request register
//   grant_cnt  out  CNT_W  accepted-handshake counter (wraps)
//   seg0       out  7      active-low hex digit {g..a} (SEG_DISPLAY_EN only)
module prio_req_encoder #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic [CNT_W-1:0] grant_cnt
`ifdef SEG_DISPLAY_EN
  ,
  output logic [6:0]       seg0
`endif
);

  // Parameter sanity check at elaboration.
  generate
    if ((N_REQ < 2) || (N_REQ > 16) || (IDX_W != $clog2(N_REQ))) begin : g_bad_params
      $error("prio_req_encoder: N_REQ must be 2..16 and IDX_W must equal clog2(N_REQ)");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             valid_d;
  logic [IDX_W-1:0] idx_d;
  logic [N_REQ-1:0] pending_d;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] remaining;

  // Highest set bit index; caller only uses the result for nonzero input.
  function automatic logic [IDX_W-1:0] prio(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Next-state, pending and counter logic.
  always_comb begin
    state_d   = state;
    valid_d   = out_valid;
    idx_d     = out_idx;
    accept    = out_valid & out_ready;
    clr       = accept ? (N_REQ'(1) << out_idx) : '0;
    remaining = pending & ~clr;
    // Set wins over clear: a same-cycle req on the accepted bit stays pending.
    pending_d = en ? (remaining | req) : remaining;
    cnt_d     = accept ? (grant_cnt + CNT_W'(1)) : grant_cnt;

    case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (en && (|pending)) begin
          idx_d   = prio(pending);
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        valid_d = 1'b1;
        if (accept) begin
          // Next offer ignores this cycle's req; it is seen one cycle later.
          if (en && (|remaining)) begin
            idx_d = prio(remaining);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      pending   <= '0;
      grant_cnt <= '0;
    end else begin
      state     <= state_d;
      out_valid <= valid_d;
      out_idx   <= idx_d;
      pending   <= pending_d;
      grant_cnt <= cnt_d;
    end
  end

`ifdef SEG_DISPLAY_EN
  logic [3:0] nib;
  logic [6:0] glyph;

  // Hex glyph (active-high gfedcba), inverted for the active-low digit.
  always_comb begin
    nib = 4'(out_idx);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    seg0 = out_valid ? ~glyph : 7'h7F;
  end
`endif

endmodule
